// File: rtl/iter_cmp_pkg.sv
// iter_cmp_pkg: shared enums and result decode for the iterative comparator
package iter_cmp_pkg;
  typedef enum logic [1:0] {CMP_LT, CMP_LE, CMP_EQ, CMP_NE} cmp_op_e;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;
  function automatic logic op_result(cmp_op_e op, logic lt_f, logic eq_f);
    return op == CMP_LT ? lt_f : op == CMP_LE ? (lt_f | eq_f) : op == CMP_EQ ? eq_f : ~eq_f;
  endfunction
endpackage

// File: rtl/iter_cmp_chunk.sv
// cmp_chunk: unsigned equality and less-than of one CHUNK-bit slice
module cmp_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] ca,
  input  logic [CHUNK-1:0] cb,
  output logic             eq,
  output logic             lt
);
  assign eq = ca == cb;
  assign lt = ca < cb;
endmodule

// File: rtl/iter_cmp.sv
// iter_cmp: MSB-first chunked LT/LE/EQ/NE comparator with valid/ready handshakes
module iter_cmp
  import iter_cmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             result,
  output logic             busy
);
  localparam int N = WIDTH / CHUNK;
  localparam int KW = N > 1 ? $clog2(N) : 1;
  localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};
  if (WIDTH < 2 || WIDTH % CHUNK != 0) begin : g_bad_params
    $error("iter_cmp: WIDTH must be >= 2 and a multiple of CHUNK");
  end
  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q;
  cmp_op_e          op_q;
  logic [KW-1:0]    k_q;
  logic             result_q;
  logic             c_eq, c_lt;
  cmp_chunk #(.CHUNK(CHUNK)) u_chunk (
    .ca(a_q[int'(k_q)*CHUNK +: CHUNK]),
    .cb(b_q[int'(k_q)*CHUNK +: CHUNK]),
    .eq(c_eq),
    .lt(c_lt)
  );
  // Signed operands are flipped to offset-binary so the chunk compare stays unsigned
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= CMP_LT;
      k_q      <= '0;
      result_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid) begin
          a_q     <= a ^ (is_signed ? MSB : '0);
          b_q     <= b ^ (is_signed ? MSB : '0);
          op_q    <= cmp_op_e'(op);
          k_q     <= KW'(N-1);
          state_q <= S_RUN;
        end
        S_RUN: if (!c_eq || k_q == '0) begin
          result_q <= op_result(op_q, c_lt, c_eq);
          state_q  <= S_DONE;
        end else begin
          k_q <= k_q - 1'b1;
        end
        S_DONE: if (out_ready) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign in_ready  = state_q == S_IDLE && !rst;
  assign out_valid = state_q == S_DONE;
  assign busy      = state_q != S_IDLE;
  assign result    = result_q;
endmodule

// File: doc/iter_cmp.md
# iter_cmp

Parametrised, multi-mode magnitude/equality comparator for the arithmetic benchmark family. It compares two WIDTH-bit operands iteratively, CHUNK bits per cycle, starting from the most significant chunk. It stops early at the first differing chunk. Operands are accepted and results returned over valid/ready handshakes, so the block sits between operand-producing and result-consuming stages. It generalises the fixed 32-bit unsigned less-than comparator to LT/LE/EQ/NE, signed or unsigned, at any width.

## Interface
- WIDTH, 32, operand width in bits; must be ≥ 2.
- CHUNK, 8, bits compared per cycle; WIDTH % CHUNK == 0 is required (elaboration error otherwise). N = WIDTH/CHUNK.
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operand request valid.
- in_ready  out  1  block can accept a request.
- a  in  WIDTH  left operand.
- b  in  WIDTH  right operand.
- op  in  2  0=LT (a<b), 1=LE (a≤b), 2=EQ, 3=NE.
- is_signed  in  1  1 = two's-complement operands.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  1  comparison outcome.
- busy  out  1  high in RUN or DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. A request is accepted on an edge where in_valid&in_ready. On acceptance:
  - latch a, b, op, is_signed;
  - if is_signed, invert the MSB of both latched operands (offset-binary). All later comparison is unsigned.
  - Set chunk index k=N-1 and go to RUN.
- RUN: compare chunk k of a and b (bits k·CHUNK+CHUNK-1 .. k·CHUNK).
  - Chunks differ: lt_f = (a_chunk < b_chunk), eq_f=0. Go to DONE.
  - Chunks equal and k==0: lt_f=0, eq_f=1. Go to DONE.
  - Chunks equal and k>0: k ← k-1. Stay in RUN.
- DONE: out_valid=1, with result registered on DONE entry:
  - LT: lt_f
  - LE: lt_f|eq_f
  - EQ: eq_f
  - NE: ~eq_f
- DONE holds until out_valid&out_ready on an edge, then goes to IDLE.
- in_ready=0 in RUN and DONE. in_valid is ignored there. No request is queued.
- Inputs a/b/op/is_signed may change freely after acceptance; latched copies are used.
- Reset, at any state including mid-RUN or DONE:
  - next state IDLE, out_valid=0, result=0, busy=0, k=0, lt_f=0, eq_f=0;
  - in_ready=0 while rst is high;
  - an aborted operation produces no result.

## Timing
- Let m = number of chunks examined: 1 ≤ m ≤ N. m = N for equal operands or when only the last chunk differs.
- out_valid rises immediately after the m-th edge following the accepting edge.
- result is stable for every cycle out_valid is high.
- Handshake edge → IDLE next cycle. The earliest next accept is that following edge.
- Minimum request period: m+2 edges.
- CHUNK=WIDTH (N=1): fixed latency of 1 edge.
- All outputs are registered or decoded directly from state. There is no combinational path from in_valid/out_ready to outputs except in_ready/out_valid state decode.

## Structure
- Package iter_cmp_pkg holds:
  - cmp_op_e enum (CMP_LT, CMP_LE, CMP_EQ, CMP_NE);
  - state enum (S_IDLE, S_RUN, S_DONE);
  - function op_result(op, lt_f, eq_f).
- Sub-module cmp_chunk: combinational, parameter CHUNK, inputs ca/cb, outputs eq and lt. It is instantiated once and fed by a k-indexed mux.
- Top-level holds the FSM, operand registers, index counter of width $clog2(N) (min 1), and result register.

## Test plan
All scenarios use WIDTH=32, CHUNK=8.
- **Reset:** hold rst 3 cycles mid-stream.
  - out_valid=0, result=0, busy=0 and in_ready=0 during reset.
  - in_ready=1 on the first cycle after release.
- **Early exit, unsigned LT:** a=0x0000_0001, b=0x8000_0000.
  - result=1, out_valid 1 edge after accept (m=1).
- **Full traversal:** a=b=0xDEAD_BEEF.
  - EQ→1, LT→0, LE→1, NE→0, each after 4 edges.
  - a=0x1234_5678, b=0x1234_5679, LT → 1 after 4 edges.
- **Signed mode:** a=0xFFFF_FFFF, b=0x0000_0001, LT.
  - is_signed=1 → result=1; is_signed=0 → result=0.
  - Signed a=0x8000_0000, b=0x7FFF_FFFF, LE → 1.
- **Backpressure:** out_ready=0 for 5 cycles after out_valid rises.
  - out_valid/result stay stable, in_ready=0, and a concurrent in_valid is not accepted.
  - out_ready=1 → IDLE next cycle, then the pending request is accepted.
- **Reset mid-RUN:** a=0x1234_5678, b=0x1234_5679; assert rst on the 2nd RUN cycle.
  - out_valid never asserts; the block returns to IDLE.
  - The next request a=3, b=2, LT yields result=0.
